stream_crop: RTL

//  Rectangular region-of-interest cropper on the pixel flow between videosampler and streamstore.

---
 rtl/stream_crop.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/stream_crop.sv
// Region-of-interest cropper: forwards only pixels inside a programmable window.
// Optional STREAM_CROP_BYPASS_EN: with enable=0 the stream passes through unchanged.
module stream_crop #(
   parameter int                          PIXEL_WIDTH    = 8,
   parameter int                          DATA_WIDTH     = 32,
   parameter int                          COORD_WIDTH    = 16,
   parameter logic [DATA_WIDTH-1:0]       DEFAULT_SCR    = '0,
   parameter logic [DATA_WIDTH-1:0]       DEFAULT_IMG_W  = 320,
   parameter logic [DATA_WIDTH-1:0]       DEFAULT_ORIGIN = '0,
   parameter logic [DATA_WIDTH-1:0]       DEFAULT_SIZE   = '0
) (
   input  logic                   clk_proc,
   input  logic                   reset_n,
   input  logic [PIXEL_WIDTH-1:0] in_data,
   input  logic                   in_dv,
   input  logic                   in_sop,
   input  logic                   in_eop,
   output logic [PIXEL_WIDTH-1:0] out_data,
   output logic                   out_dv,
   output logic                   out_sop,
   output logic                   out_eop,
   input  logic [2:0]             addr_rel_i,
   input  logic                   wr_i,
   input  logic [DATA_WIDTH-1:0]  datawr_i,
   input  logic                   rd_i,
   output logic [DATA_WIDTH-1:0]  datard_o
);

   localparam int CW = COORD_WIDTH;
   localparam int HI = DATA_WIDTH / 2;

   typedef enum logic {
      S_WAIT_SOP,
      S_IN_FRAME
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // programmed register set
   logic          r_scr_en;
   logic [CW-1:0] r_img_w;
   logic [CW-1:0] r_x0;
   logic [CW-1:0] r_y0;
   logic [CW-1:0] r_w;
   logic [CW-1:0] r_h;

   // working set latched at each accepted sop
   logic          r_en;
   logic [CW-1:0] r_wimg;
   logic [CW-1:0] r_wx0;
   logic [CW-1:0] r_wy0;
   logic [CW-1:0] r_ww;
   logic [CW-1:0] r_wh;

   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          r_win_done;
   logic          r_trunc;
   logic          r_resync;
   logic [15:0]   r_frames;

   logic          w_accept_sop;
   logic          w_pix;
   logic          w_en;
   logic [CW-1:0] w_imgw;
   logic [CW-1:0] w_x0;
   logic [CW-1:0] w_y0;
   logic [CW-1:0] w_w;
   logic [CW-1:0] w_h;
   logic [CW-1:0] w_x;
   logic [CW-1:0] w_y;
   logic [CW:0]   w_xe;
   logic [CW:0]   w_ye;
   logic [CW:0]   w_x0e;
   logic [CW:0]   w_y0e;
   logic [CW:0]   w_we;
   logic [CW:0]   w_he;
   logic          w_in_x;
   logic          w_in_y;
   logic          w_inside;
   logic          w_first;
   logic          w_last;
   logic          w_done;
   logic          w_x_wrap;
   logic          w_trunc_set;
   logic          w_st_wr;
   logic          w_o_dv;
   logic          w_o_sop;
   logic          w_o_eop;
   logic          w_frame_inc;
   logic [DATA_WIDTH-1:0] w_rd;

   assign w_accept_sop = in_dv & in_sop;
   assign w_pix = in_dv & (w_accept_sop | (r_state == S_IN_FRAME));

   // the sop pixel is judged against the freshly latched settings at (0,0)
   assign w_en   = w_accept_sop ? r_scr_en : r_en;
   assign w_imgw = w_accept_sop ? r_img_w  : r_wimg;
   assign w_x0   = w_accept_sop ? r_x0     : r_wx0;
   assign w_y0   = w_accept_sop ? r_y0     : r_wy0;
   assign w_w    = w_accept_sop ? r_w      : r_ww;
   assign w_h    = w_accept_sop ? r_h      : r_wh;
   assign w_x    = w_accept_sop ? '0       : r_x;
   assign w_y    = w_accept_sop ? '0       : r_y;
   assign w_done = w_accept_sop ? 1'b0     : r_win_done;

   // one extra bit so origin+size never wraps
   assign w_xe  = {1'b0, w_x};
   assign w_ye  = {1'b0, w_y};
   assign w_x0e = {1'b0, w_x0};
   assign w_y0e = {1'b0, w_y0};
   assign w_we  = {1'b0, w_w};
   assign w_he  = {1'b0, w_h};

   assign w_in_x = (w_xe >= w_x0e) && (w_xe < w_x0e + w_we);
   assign w_in_y = (w_ye >= w_y0e) && (w_ye < w_y0e + w_he);
   assign w_inside = w_pix & w_in_x & w_in_y;
   assign w_first = w_inside & (w_x == w_x0) & (w_y == w_y0);
   assign w_last = w_inside
                 & (w_xe + 1'b1 == w_x0e + w_we)
                 & (w_ye + 1'b1 == w_y0e + w_he);
   assign w_x_wrap = (w_x == w_imgw - 1'b1);

   assign w_trunc_set = w_pix & in_eop & w_en
                      & (w_w != '0) & (w_h != '0)
                      & ~(w_last | w_done);
   assign w_st_wr = wr_i & (addr_rel_i == 3'd4);

`ifdef STREAM_CROP_BYPASS_EN
   always_comb begin
      w_o_dv      = w_inside;
      w_o_sop     = w_first;
      w_o_eop     = w_last;
      w_frame_inc = w_last;
      if (!w_en) begin
         w_o_dv      = in_dv;
         w_o_sop     = in_dv & in_sop;
         w_o_eop     = in_dv & in_eop;
         w_frame_inc = in_dv & in_eop;
      end
   end
`else
   always_comb begin
      w_o_dv      = w_en & w_inside;
      w_o_sop     = w_en & w_first;
      w_o_eop     = w_en & w_last;
      w_frame_inc = w_en & w_last;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (w_pix && in_eop) begin
         w_state_nxt = S_WAIT_SOP;
      end else if (w_accept_sop) begin
         w_state_nxt = S_IN_FRAME;
      end
   end

   always_comb begin
      w_rd = '0;
      case (addr_rel_i)
         3'd0: w_rd[0] = r_scr_en;
         3'd1: w_rd[CW-1:0] = r_img_w;
         3'd2: begin
            w_rd[CW-1:0] = r_x0;
            w_rd[HI +: CW] = r_y0;
         end
         3'd3: begin
            w_rd[CW-1:0] = r_w;
            w_rd[HI +: CW] = r_h;
         end
         3'd4: begin
            w_rd[DATA_WIDTH-1 -: 16] = r_frames;
            w_rd[1] = r_resync;
            w_rd[0] = r_trunc;
         end
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge clk_proc or negedge reset_n) begin
      if (!reset_n) begin
         r_scr_en <= DEFAULT_SCR[0];
         r_img_w  <= DEFAULT_IMG_W[CW-1:0];
         r_x0     <= DEFAULT_ORIGIN[CW-1:0];
         r_y0     <= DEFAULT_ORIGIN[HI +: CW];
         r_w      <= DEFAULT_SIZE[CW-1:0];
         r_h      <= DEFAULT_SIZE[HI +: CW];
         datard_o <= '0;
      end else begin
         if (wr_i) begin
            case (addr_rel_i)
               3'd0: r_scr_en <= datawr_i[0];
               3'd1: r_img_w <= datawr_i[CW-1:0];
               3'd2: begin
                  r_x0 <= datawr_i[CW-1:0];
                  r_y0 <= datawr_i[HI +: CW];
               end
               3'd3: begin
                  r_w <= datawr_i[CW-1:0];
                  r_h <= datawr_i[HI +: CW];
               end
               default: ;
            endcase
         end
         if (rd_i) begin
            datard_o <= w_rd;
         end
      end
   end

   always_ff @(posedge clk_proc or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_WAIT_SOP;
         r_en       <= 1'b0;
         r_wimg     <= '0;
         r_wx0      <= '0;
         r_wy0      <= '0;
         r_ww       <= '0;
         r_wh       <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_win_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept_sop) begin
            r_en   <= r_scr_en;
            r_wimg <= r_img_w;
            r_wx0  <= r_x0;
            r_wy0  <= r_y0;
            r_ww   <= r_w;
            r_wh   <= r_h;
         end
         if (w_pix) begin
            r_x        <= w_x_wrap ? '0 : w_x + 1'b1;
            r_y        <= w_x_wrap ? w_y + 1'b1 : w_y;
            r_win_done <= w_done | w_last;
         end
      end
   end

   // status: hardware set wins over a same-cycle write-1-clear
   always_ff @(posedge clk_proc or negedge reset_n) begin
      if (!reset_n) begin
         r_trunc  <= 1'b0;
         r_resync <= 1'b0;
         r_frames <= '0;
      end else begin
         r_trunc  <= w_trunc_set
                   | (r_trunc & ~(w_st_wr & datawr_i[0]));
         r_resync <= (w_accept_sop & (r_state == S_IN_FRAME))
                   | (r_resync & ~(w_st_wr & datawr_i[1]));
         if (w_frame_inc) begin
            r_frames <= r_frames + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_proc or negedge reset_n) begin
      if (!reset_n) begin
         out_data <= '0;
         out_dv   <= 1'b0;
         out_sop  <= 1'b0;
         out_eop  <= 1'b0;
      end else begin
         out_data <= w_o_dv ? in_data : '0;
         out_dv   <= w_o_dv;
         out_sop  <= w_o_sop;
         out_eop  <= w_o_eop;
      end
   end

endmodule
